// File: rtl/imem_arbiter_n.sv
// ----------------------------------------------------------------------------
// imem_arbiter_n
//
// Purpose:
//   Shares one synchronous single-port instruction/data RAM among NCORES
//   cores. Each core raises req (with wr/addr/din held stable) and receives a
//   one-cycle ack when its access has completed. Grants rotate round-robin so
//   that no core can be starved. Read data is registered into dq and
//   broadcast to every core; the acked core(s) consume it in the ack cycle.
//
// Optional feature (macro IMEM_COALESCE_EN):
//   When defined, every core that is requesting a read of the same address as
//   the read currently being captured is acked together with the winner and
//   shares the same dq. Cores fetching in lock-step then cost a single RAM
//   access. When undefined, only the granted core is acked.
//
// Parameters:
//   NCORES  - number of requesting cores (>= 2)
//   AW      - RAM address width
//   DW      - RAM data width
//   RAM_LAT - RAM read latency in cycles (>= 1)
//
// Ports:
//   clk       in   clock, all logic on rising edge
//   rst_n     in   synchronous active-low reset
//   req       in   [NCORES]     per-core request, held until ack
//   wr        in   [NCORES]     per-core write qualifier (1 = write)
//   addr      in   [NCORES*AW]  packed addresses, core i = [i*AW +: AW]
//   din       in   [NCORES*DW]  packed write data, core i = [i*DW +: DW]
//   ack       out  [NCORES]     one-cycle completion pulse per core
//   dq        out  [DW]         registered read data, broadcast
//   ram_addr  out  [AW]         RAM address
//   ram_din   out  [DW]         RAM write data
//   ram_wren  out               RAM write enable
//   ram_q     in   [DW]         RAM read data
//
// Transaction timing (E0 = grant edge):
//   read : RD_WAIT for RAM_LAT+1 cycles, dq/ack captured at E0+RAM_LAT+1,
//          RESP cycle, back in IDLE at E0+RAM_LAT+2.
//   write: ram_wren high E0..E0+1, ack during the following cycle,
//          back in IDLE at E0+2.
// ----------------------------------------------------------------------------
module imem_arbiter_n #(
  parameter int NCORES  = 4,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int RAM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCORES-1:0]    req,
  input  logic [NCORES-1:0]    wr,
  input  logic [NCORES*AW-1:0] addr,
  input  logic [NCORES*DW-1:0] din,
  output logic [NCORES-1:0]    ack,
  output logic [DW-1:0]        dq,
  output logic [AW-1:0]        ram_addr,
  output logic [DW-1:0]        ram_din,
  output logic                 ram_wren,
  input  logic [DW-1:0]        ram_q
);

  // Width of a core index / round-robin pointer.
  localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;
  // Width of the read-latency counter (must hold the value RAM_LAT).
  localparam int CW = (RAM_LAT > 0) ? $clog2(RAM_LAT + 1) : 1;

  localparam logic [PW:0]     NC_EXT   = (PW + 1)'(NCORES);
  localparam logic [CW-1:0]   LAT_LAST = CW'(RAM_LAT);
  localparam logic [NCORES-1:0] ONE_HOT0 = {{(NCORES - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RESP    = 2'd2,
    ST_WR      = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [PW-1:0]       r_rr_ptr;
  logic [PW-1:0]       r_winner;
  logic [AW-1:0]       r_ram_addr;
  logic [DW-1:0]       r_ram_din;
  logic                r_ram_wren;
  logic [NCORES-1:0]   r_ack;
  logic [DW-1:0]       r_dq;

  // --------------------------------------------------------------------------
  // Next-state values
  // --------------------------------------------------------------------------
  state_t              w_state_next;
  logic [CW-1:0]       w_cnt_next;
  logic [PW-1:0]       w_rr_ptr_next;
  logic [PW-1:0]       w_winner_next;
  logic [AW-1:0]       w_ram_addr_next;
  logic [DW-1:0]       w_ram_din_next;
  logic                w_ram_wren_next;
  logic [NCORES-1:0]   w_ack_next;
  logic [DW-1:0]       w_dq_next;

  // --------------------------------------------------------------------------
  // Per-core unpacking and read-coalesce match
  // --------------------------------------------------------------------------
  logic [AW-1:0]       w_addr [NCORES];
  logic [DW-1:0]       w_din  [NCORES];
  logic [NCORES-1:0]   w_coal;

  genvar gi;
  generate
    for (gi = 0; gi < NCORES; gi++) begin : g_core
      assign w_addr[gi] = addr[gi*AW +: AW];
      assign w_din[gi]  = din[gi*DW +: DW];
`ifdef IMEM_COALESCE_EN
      // Compared against the live request vector in the capture cycle, so a
      // core that raised its read after the grant can still ride along.
      assign w_coal[gi] = req[gi] & ~wr[gi] & (w_addr[gi] == r_ram_addr);
`else
      assign w_coal[gi] = 1'b0;
`endif
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Round-robin winner selection
  //
  // The request vector is rotated so that bit 0 corresponds to the core at
  // r_rr_ptr; the lowest set bit of the rotated vector is then the offset of
  // the winner from the pointer. Doubling the vector before shifting makes
  // the rotation a plain right shift.
  // --------------------------------------------------------------------------
  logic [2*NCORES-1:0] w_req_dbl;
  logic [NCORES-1:0]   w_req_rot;
  logic [PW-1:0]       w_off;
  logic                w_any_req;
  logic [PW:0]         w_sum;
  logic [PW:0]         w_sum_wrap;
  logic [PW-1:0]       w_grant_idx;
  logic [PW:0]         w_rr_sum;
  logic [PW:0]         w_rr_sum_wrap;
  logic [PW-1:0]       w_rr_after;

  assign w_req_dbl = {req, req} >> r_rr_ptr;
  assign w_req_rot = w_req_dbl[NCORES-1:0];
  assign w_any_req = |req;

  always_comb begin
    w_off = '0;
    // Descending scan so the lowest set offset is the one left standing.
    for (int k = NCORES - 1; k >= 0; k--) begin
      if (w_req_rot[k]) begin
        w_off = PW'(k);
      end
    end
  end

  // Winner = (rr_ptr + offset) mod NCORES; both operands are < NCORES so one
  // conditional subtraction is enough.
  assign w_sum         = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_sum_wrap    = w_sum - NC_EXT;
  assign w_grant_idx   = (w_sum >= NC_EXT) ? w_sum_wrap[PW-1:0] : w_sum[PW-1:0];

  // Pointer after grant = (winner + 1) mod NCORES.
  assign w_rr_sum      = {1'b0, w_grant_idx} + {{PW{1'b0}}, 1'b1};
  assign w_rr_sum_wrap = w_rr_sum - NC_EXT;
  assign w_rr_after    = (w_rr_sum >= NC_EXT) ? w_rr_sum_wrap[PW-1:0] : w_rr_sum[PW-1:0];

  // --------------------------------------------------------------------------
  // Served masks
  // --------------------------------------------------------------------------
  logic [NCORES-1:0] w_winner_oh;
  logic [NCORES-1:0] w_served;

  assign w_winner_oh = ONE_HOT0 << r_winner;
  // The winner is always served even if it has dropped req meanwhile.
  assign w_served    = w_winner_oh | w_coal;

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    // Hold everything by default; ack and write enable are pulses.
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_rr_ptr_next   = r_rr_ptr;
    w_winner_next   = r_winner;
    w_ram_addr_next = r_ram_addr;
    w_ram_din_next  = r_ram_din;
    w_ram_wren_next = 1'b0;
    w_ack_next      = '0;
    w_dq_next       = r_dq;

    unique case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_winner_next   = w_grant_idx;
          w_rr_ptr_next   = w_rr_after;
          w_ram_addr_next = w_addr[w_grant_idx];
          if (wr[w_grant_idx]) begin
            w_ram_din_next  = w_din[w_grant_idx];
            w_ram_wren_next = 1'b1;
            w_state_next    = ST_WR;
          end else begin
            w_cnt_next   = '0;
            w_state_next = ST_RD_WAIT;
          end
        end
      end

      ST_RD_WAIT: begin
        // RAM_LAT+1 cycles here: one for the RAM to register the address,
        // RAM_LAT for the data to appear on ram_q.
        if (r_cnt == LAT_LAST) begin
          w_dq_next    = ram_q;
          w_ack_next   = w_served;
          w_state_next = ST_RESP;
        end else begin
          w_cnt_next = r_cnt + {{(CW - 1){1'b0}}, 1'b1};
        end
      end

      ST_WR: begin
        // The write has been taken by the RAM at this edge; ack the writer.
        w_ack_next   = w_winner_oh;
        w_state_next = ST_RESP;
      end

      ST_RESP: begin
        // Ack is visible during this cycle; return to arbitration. A core
        // still holding req in the next IDLE cycle is a fresh request.
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_rr_ptr   <= '0;
      r_winner   <= '0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_ram_wren <= 1'b0;
      r_ack      <= '0;
      r_dq       <= '0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_rr_ptr   <= w_rr_ptr_next;
      r_winner   <= w_winner_next;
      r_ram_addr <= w_ram_addr_next;
      r_ram_din  <= w_ram_din_next;
      r_ram_wren <= w_ram_wren_next;
      r_ack      <= w_ack_next;
      r_dq       <= w_dq_next;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ack      = r_ack;
  assign dq       = r_dq;
  assign ram_addr = r_ram_addr;
  assign ram_din  = r_ram_din;
  assign ram_wren = r_ram_wren;

endmodule
